cache_line_xfer: RTL
====================

# cache_line_xfer

Line-to-beat transfer sequencer between the cache controller and `axi_4_lite_master`.
- Writeback: takes one full cache line and serialises it into `WORDS_PER_LINE` single-word writes on the master's `wb_*` port.
- Refill: issues `WORDS_PER_LINE` word read addresses on `addr_*` and reassembles the returning `mem_*` data into one line.
- One line operation in flight at a time; completion is reported back to the cache on a `resp` handshake.

## Interface
Parameters:
- `WORDS_PER_LINE`, default 4: data words per cache line; power of two, ≥2.
- `ADDR_WIDTH`, `DATA_WIDTH`, `DATA_BYTES`: taken from `cache_pkg`.
- `LINE_WIDTH`: local, `WORDS_PER_LINE*DATA_WIDTH`.

Ports (all signals sampled on `aclk_i`):
- `aclk_i` in 1 — the single clock.
- `arstn_i` in 1 — reset, asynchronous, active-low.
- `req_valid_i` in 1 — cache requests a line operation.
- `req_ready_o` out 1 — block accepts a request (idle).
- `req_we_i` in 1 — 1 = writeback, 0 = refill.
- `req_addr_i` in ADDR_WIDTH — line address; low offset bits are ignored.
- `req_line_i` in LINE_WIDTH — writeback data; word k at `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `resp_valid_o` out 1 — operation complete.
- `resp_ready_i` in 1 — cache consumes the response.
- `resp_we_o` out 1 — echo of `req_we_i` for the completed operation.
- `resp_line_o` out LINE_WIDTH — refilled line; holds the previous value after a writeback.
- `wb_valid_o` out 1 — writeback beat valid.
- `wb_data_o` out DATA_WIDTH — writeback beat data.
- `wb_addr_o` out ADDR_WIDTH — writeback beat address.
- `mem_ready_i` in 1 — master accepts the writeback beat.
- `addr_req_o` out 1 — refill read-address valid.
- `addr_o` out ADDR_WIDTH — refill word address.
- `addr_ready_i` in 1 — master accepts the read address.
- `mem_valid_i` in 1 — read data beat valid.
- `mem_data_i` in DATA_WIDTH — read data beat.
- `mem_ready_o` out 1 — block accepts the read data beat.

## Operation
- States: IDLE, WB, RD, RESP. The `xfer_state_t` enum lives in `cache_pkg`.
- Reset values: state IDLE; all counters 0; `resp_line_o` 0; `resp_we_o` 0; all valid/req outputs 0; `req_ready_o` 1.
- Request acceptance:
  - IDLE: `req_ready_o`=1. On `req_valid_i && req_ready_o`, latch the line base (`req_addr_i` with low `$clog2(WORDS_PER_LINE*DATA_BYTES)` bits cleared), `req_we_i` and `req_line_i`.
  - Next state is WB when `req_we_i`=1, RD otherwise.
- Beat address for beat k: `base + k*DATA_BYTES`. Byte-offset bits are always 0.
- WB:
  - `wb_valid_o`=1; data and address come from beat counter `tx_cnt`.
  - `tx_cnt` increments on each `wb_valid_o && mem_ready_i`.
  - On the handshake with `tx_cnt == WORDS_PER_LINE-1`, go to RESP.
  - The write response is not tracked; the master holds `bready` high.
- RD:
  - `addr_req_o`=1 while `ar_cnt < WORDS_PER_LINE`. `ar_cnt` increments on `addr_req_o && addr_ready_i`.
  - `mem_ready_o`=1 while `rx_cnt < WORDS_PER_LINE`. Each `mem_valid_i && mem_ready_o` writes word `rx_cnt` of the line buffer, then increments `rx_cnt`.
  - Addresses may run ahead of data. Data returns in order, so `rx_cnt` selects the word.
  - Go to RESP on the data handshake with `rx_cnt == WORDS_PER_LINE-1`. By construction, all addresses have already been issued by then.
  - Address and data handshakes may occur in the same cycle; the two counters are independent.
- RESP:
  - `resp_valid_o`=1, with `resp_line_o` and `resp_we_o` stable.
  - On `resp_ready_i`, clear counters and go to IDLE. The next request can be accepted the following cycle.
- Outside the active state, `wb_valid_o`, `addr_req_o` and `mem_ready_o` are 0. `mem_valid_i` in IDLE is ignored and not accepted.
- Counter width is `$clog2(WORDS_PER_LINE)+1`, so the counters never wrap within an operation.
- Reset mid-operation: return immediately to IDLE. Any partial line is discarded and no response is produced. `axi_4_lite_master` FIFOs share `arstn_i`.

## Timing
- Request handshake in cycle 0 → first beat presented in cycle 1 (WB or RD). All outputs are registered or derived from state/counters only.
- Writeback with `mem_ready_i` held at 1: beats in cycles 1..W, `resp_valid_o` in cycle W+1. Each `mem_ready_i` low cycle adds one cycle.
- Refill: `addr_req_o` in cycles 1..W when `addr_ready_i`=1. Response is 1 cycle after the last data beat.
- `wb_data_o`/`wb_addr_o` and `addr_o` are held stable while the corresponding valid is high and not accepted.
- `resp_valid_o` stays high until `resp_ready_i`. Zero-latency consume: RESP lasts exactly 1 cycle.

## Structure
- `cache_pkg` holds the `xfer_state_t` typedef and the existing `ADDR_WIDTH`/`DATA_WIDTH`/`DATA_BYTES` constants.
- No sub-module. The line buffer, the three counters and the FSM are inline.
- Instantiated beside `axi_4_lite_master`, with its `wb_*`, `addr_*` and `mem_*` ports wired directly.

## Test plan
All scenarios use W=4 and 32-bit data/address.
- Writeback, `req_addr_i`=0x1000_0004, line {0xDDDD,0xCCCC,0xBBBB,0xAAAA}, `mem_ready_i`=1 → beats (0x1000_0000,0xAAAA), (0x1000_0004,0xBBBB), (0x1000_0008,0xCCCC), (0x1000_000C,0xDDDD) in cycles 1–4; `resp_valid_o` with `resp_we_o`=1 in cycle 5.
- Writeback with `mem_ready_i` low in cycles 2–3 → beat 1 held stable for 3 cycles; response in cycle 7.
- Refill at 0x2000_0010, `addr_ready_i`=1, data 1,2,3,4 returned 3 cycles after each address → addresses 0x2000_0010..0x2000_001C; `resp_line_o`={4,3,2,1}, `resp_we_o`=0.
- Refill with `addr_ready_i`=0 for 2 cycles and data back-to-back afterwards; simultaneous address and data handshakes → exactly 4 addresses and 4 data words; `mem_ready_o` drops after the 4th word.
- `resp_ready_i` held low 5 cycles → `resp_valid_o` and `resp_line_o` stable; `req_ready_o`=0 until consumed.
- `arstn_i` asserted after beat 2 of a refill → all outputs at reset values immediately; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache-side constants and the line-transfer sequencer state encoding.
package cache_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int DATA_BYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RD   = 2'd2,
        RESP = 2'd3
    } xfer_state_t;

endpackage

// File: rtl/cache_line_xfer.sv
// Line<->beat sequencer: writeback serialises a line into word writes, refill gathers word reads into a line.
// First beat one cycle after request; every beat, address and the response stall on their own ready.
module cache_line_xfer
    import cache_pkg::*;
#(
    parameter  int WORDS_PER_LINE = 4,
    localparam int LINE_WIDTH     = WORDS_PER_LINE * DATA_WIDTH
) (
    input  logic                  aclk_i,
    input  logic                  arstn_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [LINE_WIDTH-1:0] req_line_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic                  resp_we_o,
    output logic [LINE_WIDTH-1:0] resp_line_o,
    output logic                  wb_valid_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic [ADDR_WIDTH-1:0] wb_addr_o,
    input  logic                  mem_ready_i,
    output logic                  addr_req_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    input  logic                  addr_ready_i,
    input  logic                  mem_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic                  mem_ready_o
);

    localparam int IW   = $clog2(WORDS_PER_LINE);
    localparam int CW   = IW + 1;
    localparam int BOFF = $clog2(DATA_BYTES);
    localparam int LOFF = $clog2(WORDS_PER_LINE * DATA_BYTES);
    localparam logic [CW-1:0]         LAST      = CW'(WORDS_PER_LINE - 1);
    localparam logic [CW-1:0]         FULL      = CW'(WORDS_PER_LINE);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~((ADDR_WIDTH'(1) << LOFF) - ADDR_WIDTH'(1));

    xfer_state_t           r_state;
    xfer_state_t           w_state_nxt;
    logic [CW-1:0]         r_tx_cnt;
    logic [CW-1:0]         r_ar_cnt;
    logic [CW-1:0]         r_rx_cnt;
    logic [ADDR_WIDTH-1:0] r_base;
    logic                  r_we;
    logic [LINE_WIDTH-1:0] r_wb_line;
    logic [LINE_WIDTH-1:0] r_resp_line;

    logic w_req_hs;
    logic w_wb_hs;
    logic w_ar_hs;
    logic w_rx_hs;
    logic w_resp_hs;

    // Base has the line offset cleared, so OR-ing in the word index is an add.
    function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [CW-1:0]         cnt);
        return base | (ADDR_WIDTH'(cnt[IW-1:0]) << BOFF);
    endfunction

    always_comb begin
        w_state_nxt  = r_state;
        req_ready_o  = 1'b0;
        wb_valid_o   = 1'b0;
        addr_req_o   = 1'b0;
        mem_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) w_state_nxt = req_we_i ? WB : RD;
            end
            WB: begin
                wb_valid_o = 1'b1;
                if (mem_ready_i && r_tx_cnt == LAST) w_state_nxt = RESP;
            end
            RD: begin
                addr_req_o  = (r_ar_cnt < FULL);
                mem_ready_o = (r_rx_cnt < FULL);
                if (mem_valid_i && r_rx_cnt == LAST) w_state_nxt = RESP;
            end
            RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_req_hs  = req_valid_i && req_ready_o;
    assign w_wb_hs   = wb_valid_o && mem_ready_i;
    assign w_ar_hs   = addr_req_o && addr_ready_i;
    assign w_rx_hs   = mem_valid_i && mem_ready_o;
    assign w_resp_hs = resp_valid_o && resp_ready_i;

    assign wb_data_o   = r_wb_line[int'(r_tx_cnt[IW-1:0]) * DATA_WIDTH +: DATA_WIDTH];
    assign wb_addr_o   = beat_addr(r_base, r_tx_cnt);
    assign addr_o      = beat_addr(r_base, r_ar_cnt);
    assign resp_line_o = r_resp_line;
    assign resp_we_o   = r_we;

    always_ff @(posedge aclk_i or negedge arstn_i) begin
        if (!arstn_i) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge aclk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_base    <= '0;
            r_we      <= 1'b0;
            r_wb_line <= '0;
        end else if (w_req_hs) begin
            r_base    <= req_addr_i & LINE_MASK;
            r_we      <= req_we_i;
            r_wb_line <= req_line_i;
        end
    end

    // Address and data counters are independent: addresses may run ahead of data.
    always_ff @(posedge aclk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_tx_cnt    <= '0;
            r_ar_cnt    <= '0;
            r_rx_cnt    <= '0;
            r_resp_line <= '0;
        end else if (w_resp_hs) begin
            r_tx_cnt <= '0;
            r_ar_cnt <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_wb_hs) r_tx_cnt <= r_tx_cnt + 1'b1;
            if (w_ar_hs) r_ar_cnt <= r_ar_cnt + 1'b1;
            if (w_rx_hs) begin
                r_resp_line[int'(r_rx_cnt[IW-1:0]) * DATA_WIDTH +: DATA_WIDTH] <= mem_data_i;
                r_rx_cnt <= r_rx_cnt + 1'b1;
            end
        end
    end

endmodule
